// File: rtl/sar_a2d_nch.sv
// Multi-channel successive-approximation ADC sequencer.
// Shared sample/hold, per-channel SAR DAC codes, optional averaging.
module sar_a2d_nch #(
  parameter int NCH        = 2,
  parameter int WIDTH      = 12,
  parameter int SMPL_CYC   = 8,
  parameter int SETTLE_CYC = 4,
  parameter int AVG_LOG2   = 0,
  parameter int SIGNED_OUT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   strt_cnv,
  input  logic                   abort,
  input  logic [NCH-1:0]         gt,
  output logic                   smpl,
  output logic [NCH*WIDTH-1:0]   dac,
  output logic [NCH*WIDTH-1:0]   rslt,
  output logic                   cnv_cmplt,
  output logic                   busy
);

  localparam int AW   = WIDTH + AVG_LOG2;
  localparam int NAVG = 1 << AVG_LOG2;
  localparam int MAXC = (SMPL_CYC > SETTLE_CYC) ? SMPL_CYC : SETTLE_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int BW   = $clog2(WIDTH);
  localparam int NW   = AVG_LOG2 + 1;

  localparam logic [CW-1:0]    SMPL_LAST = CW'(SMPL_CYC - 1);
  localparam logic [CW-1:0]    SET_LAST  = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0]    C1        = CW'(1);
  localparam logic [BW-1:0]    BTOP      = BW'(WIDTH - 1);
  localparam logic [BW-1:0]    B1        = BW'(1);
  localparam logic [NW-1:0]    NLAST     = NW'(NAVG - 1);
  localparam logic [NW-1:0]    N1        = NW'(1);
  localparam logic [WIDTH-1:0] MID       = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SMPL = 2'd1,
    CONV = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                       state;
  logic [CW-1:0]                cnt;
  logic [BW-1:0]                bidx;
  logic [NW-1:0]                navg;
  logic [NCH-1:0][WIDTH-1:0]    dac_q;
  logic [NCH-1:0][WIDTH-1:0]    rslt_q;
  logic [NCH-1:0][AW-1:0]       acc;
  logic [NCH-1:0][WIDTH-1:0]    nxt;
  logic [NCH-1:0][WIDTH-1:0]    res;

  assign dac  = dac_q;
  assign rslt = rslt_q;

  // Resolve the current trial bit and arm the next one for every channel
  always_comb begin
    nxt = dac_q;
    for (int c = 0; c < NCH; c++) begin
      if (!gt[c]) nxt[c][bidx] = 1'b0;
      if (bidx != '0) nxt[c][bidx - B1] = 1'b1;
    end
  end

  // Averaged result, optionally converted from offset binary
  always_comb begin
    res = '0;
    for (int c = 0; c < NCH; c++) begin
      res[c] = acc[c][AVG_LOG2 +: WIDTH];
      if (SIGNED_OUT != 0) res[c][WIDTH-1] = ~res[c][WIDTH-1];
    end
  end

  // Sequencer: sample, bit trials, accumulate, complete
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bidx      <= '0;
      navg      <= '0;
      dac_q     <= '0;
      rslt_q    <= '0;
      acc       <= '0;
      smpl      <= 1'b0;
      busy      <= 1'b0;
      cnv_cmplt <= 1'b0;
    end else begin
      cnv_cmplt <= 1'b0;
      unique case (state)
        IDLE: begin
          if (strt_cnv) begin
            state <= SMPL;
            smpl  <= 1'b1;
            busy  <= 1'b1;
            cnt   <= '0;
            navg  <= '0;
            acc   <= '0;
          end
        end
        SMPL: begin
          if (abort) begin
            state <= IDLE;
            smpl  <= 1'b0;
            busy  <= 1'b0;
            acc   <= '0;
          end else if (cnt == SMPL_LAST) begin
            state <= CONV;
            smpl  <= 1'b0;
            cnt   <= '0;
            bidx  <= BTOP;
            for (int c = 0; c < NCH; c++) dac_q[c] <= MID;
          end else begin
            cnt <= cnt + C1;
          end
        end
        CONV: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            acc   <= '0;
          end else if (cnt == SET_LAST) begin
            cnt   <= '0;
            dac_q <= nxt;
            if (bidx == '0) begin
              for (int c = 0; c < NCH; c++)
                acc[c] <= acc[c] + AW'(nxt[c]);
              if (navg == NLAST) begin
                state <= DONE;
              end else begin
                navg  <= navg + N1;
                state <= SMPL;
                smpl  <= 1'b1;
              end
            end else begin
              bidx <= bidx - B1;
            end
          end else begin
            cnt <= cnt + C1;
          end
        end
        DONE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          cnv_cmplt <= 1'b1;
          rslt_q    <= res;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_a2d_nch.sv
// Directed bench for sar_a2d_nch: three parameter sets side by side,
// ideal comparator model gt = vin >= dac per channel.
module tb_sar_a2d_nch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        strt [3];
  logic        abrt [3];
  logic [11:0] vin [3][2];
  logic [1:0]  gt_w [3];
  logic        smpl_w [3];
  logic        cmplt_w [3];
  logic        busy_w [3];
  logic [23:0] dac_w [3];
  logic [23:0] rslt_w [3];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Ideal comparator per channel
  always_comb begin
    for (int s = 0; s < 3; s++) begin
      gt_w[s] = '0;
      for (int c = 0; c < 2; c++)
        gt_w[s][c] = vin[s][c] >= dac_w[s][c*12 +: 12];
    end
  end

  sar_a2d_nch #(
    .NCH(2), .WIDTH(12), .SMPL_CYC(8), .SETTLE_CYC(4),
    .AVG_LOG2(0), .SIGNED_OUT(1)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .strt_cnv(strt[0]), .abort(abrt[0]),
    .gt(gt_w[0]), .smpl(smpl_w[0]), .dac(dac_w[0]), .rslt(rslt_w[0]),
    .cnv_cmplt(cmplt_w[0]), .busy(busy_w[0])
  );

  sar_a2d_nch #(
    .NCH(2), .WIDTH(12), .SMPL_CYC(8), .SETTLE_CYC(4),
    .AVG_LOG2(0), .SIGNED_OUT(0)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .strt_cnv(strt[1]), .abort(abrt[1]),
    .gt(gt_w[1]), .smpl(smpl_w[1]), .dac(dac_w[1]), .rslt(rslt_w[1]),
    .cnv_cmplt(cmplt_w[1]), .busy(busy_w[1])
  );

  sar_a2d_nch #(
    .NCH(2), .WIDTH(12), .SMPL_CYC(8), .SETTLE_CYC(4),
    .AVG_LOG2(2), .SIGNED_OUT(0)
  ) u_c (
    .clk(clk), .rst_n(rst_n), .strt_cnv(strt[2]), .abort(abrt[2]),
    .gt(gt_w[2]), .smpl(smpl_w[2]), .dac(dac_w[2]), .rslt(rslt_w[2]),
    .cnv_cmplt(cmplt_w[2]), .busy(busy_w[2])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request on instance sel; lat = edges from start edge to
  // cnv_cmplt (-1 if it never came), pulses/hi = smpl activity.
  task automatic run_conv(input int sel, output int lat,
                          output int pulses, output int hi);
    logic prev;
    strt[sel] = 1'b1;
    tick();
    strt[sel] = 1'b0;
    lat = -1;
    pulses = 0;
    hi = 0;
    prev = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (smpl_w[sel] && !prev) begin
        pulses++;
        if (sel == 2) vin[2][0] = 12'h100 + 12'(pulses - 1);
      end
      prev = smpl_w[sel];
      if (smpl_w[sel]) hi++;
      if (cmplt_w[sel]) begin
        lat = i;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    for (int s = 0; s < 3; s++) begin
      n_chk++;
      if ({smpl_w[s], busy_w[s], cmplt_w[s]} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_ctl[%0d] got %b want 000", s,
                 {smpl_w[s], busy_w[s], cmplt_w[s]});
      end
      n_chk++;
      if ({dac_w[s], rslt_w[s]} !== 48'h0) begin
        n_fail++;
        $display("FAIL reset_data[%0d] got %h want 0", s,
                 {dac_w[s], rslt_w[s]});
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_signed();
    int lat, pl, hi;
    vin[0][0] = 12'hA53;
    vin[0][1] = 12'h000;
    run_conv(0, lat, pl, hi);
    n_chk++;
    if (lat !== 57) begin
      n_fail++;
      $display("FAIL signed_latency got %0d want 57", lat);
    end
    n_chk++;
    if (rslt_w[0] !== 24'h800253) begin
      n_fail++;
      $display("FAIL signed_rslt got %h want 800253", rslt_w[0]);
    end
    n_chk++;
    if (dac_w[0] !== 24'h000A53) begin
      n_fail++;
      $display("FAIL signed_dac got %h want 000a53", dac_w[0]);
    end
    n_chk++;
    if (hi !== 8) begin
      n_fail++;
      $display("FAIL signed_smpl_hi got %0d want 8", hi);
    end
    tick();
    n_chk++;
    if ({cmplt_w[0], busy_w[0]} !== 2'b00) begin
      n_fail++;
      $display("FAIL signed_after got %b want 00",
               {cmplt_w[0], busy_w[0]});
    end
  endtask

  task automatic test_unsigned();
    int lat, pl, hi;
    vin[1][0] = 12'hFFF;
    vin[1][1] = 12'h800;
    run_conv(1, lat, pl, hi);
    n_chk++;
    if (lat !== 57) begin
      n_fail++;
      $display("FAIL unsigned_latency got %0d want 57", lat);
    end
    n_chk++;
    if (rslt_w[1] !== 24'h800FFF) begin
      n_fail++;
      $display("FAIL unsigned_rslt got %h want 800fff", rslt_w[1]);
    end
    n_chk++;
    if (hi !== 8 || pl !== 1) begin
      n_fail++;
      $display("FAIL unsigned_smpl got hi=%0d pulses=%0d want 8/1",
               hi, pl);
    end
  endtask

  task automatic test_average();
    int lat, pl, hi;
    vin[2][0] = 12'h100;
    vin[2][1] = 12'h7FF;
    run_conv(2, lat, pl, hi);
    n_chk++;
    if (pl !== 4) begin
      n_fail++;
      $display("FAIL avg_pulses got %0d want 4", pl);
    end
    n_chk++;
    if (hi !== 32) begin
      n_fail++;
      $display("FAIL avg_smpl_hi got %0d want 32", hi);
    end
    n_chk++;
    if (lat !== 225) begin
      n_fail++;
      $display("FAIL avg_latency got %0d want 225", lat);
    end
    n_chk++;
    if (rslt_w[2] !== 24'h7FF101) begin
      n_fail++;
      $display("FAIL avg_rslt got %h want 7ff101", rslt_w[2]);
    end
  endtask

  task automatic test_back_to_back();
    int c1, c2, s1, s2;
    logic prev;
    c1 = -1; c2 = -1; s1 = -1; s2 = -1;
    prev = 1'b0;
    vin[0][0] = 12'hA53;
    vin[0][1] = 12'h000;
    strt[0] = 1'b1;
    tick();
    for (int i = 0; i < 130; i++) begin
      if (smpl_w[0] && !prev) begin
        if (s1 < 0) s1 = i;
        else if (s2 < 0) s2 = i;
      end
      prev = smpl_w[0];
      if (cmplt_w[0]) begin
        if (c1 < 0) c1 = i;
        else if (c2 < 0) c2 = i;
      end
      if (i == 57) begin
        n_chk++;
        if (busy_w[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_idle_gap got busy=%b want 0", busy_w[0]);
        end
      end
      tick();
    end
    strt[0] = 1'b0;
    n_chk++;
    if (s1 !== 0 || s2 !== 58) begin
      n_fail++;
      $display("FAIL b2b_smpl got %0d,%0d want 0,58", s1, s2);
    end
    n_chk++;
    if (c1 !== 57 || c2 !== 115) begin
      n_fail++;
      $display("FAIL b2b_cmplt got %0d,%0d want 57,115", c1, c2);
    end
    n_chk++;
    if (rslt_w[0] !== 24'h800253) begin
      n_fail++;
      $display("FAIL b2b_rslt got %h want 800253", rslt_w[0]);
    end
    for (int i = 0; i < 70 && busy_w[0]; i++) tick();
    tick();
  endtask

  task automatic test_abort();
    int seen;
    vin[0][0] = 12'h123;
    vin[0][1] = 12'h456;
    strt[0] = 1'b1;
    tick();
    strt[0] = 1'b0;
    for (int i = 0; i < 27; i++) tick();
    abrt[0] = 1'b1;
    tick();
    abrt[0] = 1'b0;
    n_chk++;
    if ({busy_w[0], smpl_w[0]} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_busy got %b want 00", {busy_w[0], smpl_w[0]});
    end
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      if (cmplt_w[0]) seen++;
      tick();
    end
    n_chk++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL abort_cmplt got %0d pulses want 0", seen);
    end
    n_chk++;
    if (rslt_w[0] !== 24'h800253) begin
      n_fail++;
      $display("FAIL abort_rslt got %h want 800253", rslt_w[0]);
    end
    strt[0] = 1'b1;
    abrt[0] = 1'b1;
    tick();
    strt[0] = 1'b0;
    abrt[0] = 1'b0;
    n_chk++;
    if ({busy_w[0], smpl_w[0]} !== 2'b11) begin
      n_fail++;
      $display("FAIL start_wins got %b want 11", {busy_w[0], smpl_w[0]});
    end
  endtask

  task automatic test_reset_midconv();
    int lat, pl, hi;
    for (int i = 0; i < 20; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({smpl_w[0], busy_w[0], cmplt_w[0]} !== 3'b000) begin
      n_fail++;
      $display("FAIL midrst_ctl got %b want 000",
               {smpl_w[0], busy_w[0], cmplt_w[0]});
    end
    n_chk++;
    if ({dac_w[0], rslt_w[0]} !== 48'h0) begin
      n_fail++;
      $display("FAIL midrst_data got %h want 0", {dac_w[0], rslt_w[0]});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vin[0][0] = 12'hA53;
    vin[0][1] = 12'h000;
    run_conv(0, lat, pl, hi);
    n_chk++;
    if (lat !== 57 || rslt_w[0] !== 24'h800253) begin
      n_fail++;
      $display("FAIL post_rst_conv got lat=%0d rslt=%h want 57/800253",
               lat, rslt_w[0]);
    end
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      strt[s] = 1'b0;
      abrt[s] = 1'b0;
      vin[s][0] = '0;
      vin[s][1] = '0;
    end
    test_reset();
    test_signed();
    test_unsigned();
    test_average();
    test_back_to_back();
    test_abort();
    test_reset_midconv();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
